// File: rtl/tracker_pkg.sv
// tracker_pkg: FSM state encoding and overflow mode constants for multi_axis_tracker.
package tracker_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACK  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    UPD  = 3'd4
  } state_t;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_WRAP = 2'b10;
endpackage

// File: rtl/axis_step.sv
// axis_step: one axis of position + velocity with hold/saturate/wrap overflow handling.
module axis_step
  import tracker_pkg::*;
#(
  parameter int PW = 8,
  parameter int VW = 4
) (
  input  logic [PW-1:0] pos,
  input  logic [VW-1:0] v,
  input  logic [1:0]    mode,
  output logic [PW-1:0] new_pos,
  output logic          ovf
);
  logic [PW:0]   sum;
  logic [PW-1:0] sat;
  assign sum = {pos[PW-1], pos} + {{(PW+1-VW){v[VW-1]}}, v};
  // The extra sign bit disagrees with the top bit of the result exactly when the sum left the range
  assign ovf = sum[PW] ^ sum[PW-1];
  assign sat = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  assign new_pos = (!ovf || mode == MODE_WRAP) ? sum[PW-1:0] : mode == MODE_SAT ? sat : pos;
endmodule

// File: rtl/multi_axis_tracker.sv
// multi_axis_tracker: N-axis position tracker fetching per-step velocities over 4-phase handshakes.
module multi_axis_tracker
  import tracker_pkg::*;
#(
  parameter int N_AX = 2,
  parameter int PW   = 8,
  parameter int VW   = 4,
  parameter int CW   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 soc_p,
  output logic                 eoc_p,
  output logic                 soc_v,
  input  logic [N_AX-1:0]      eoc_v,
  input  logic [N_AX*VW-1:0]   v,
  input  logic [1:0]           mode,
  output logic [N_AX*PW-1:0]   pos,
  output logic [N_AX-1:0]      ovf,
  output logic [CW-1:0]        step_cnt
);
  state_t              state, nxt;
  logic [1:0]          mode_r;
  logic [N_AX*VW-1:0]  v_r;
  logic [N_AX*PW-1:0]  new_pos;
  logic [N_AX-1:0]     new_ovf;
  for (genvar i = 0; i < N_AX; i++) begin : g_ax
    axis_step #(.PW(PW), .VW(VW)) u_ax (
      .pos    (pos[i*PW +: PW]),
      .v      (v_r[i*VW +: VW]),
      .mode   (mode_r),
      .new_pos(new_pos[i*PW +: PW]),
      .ovf    (new_ovf[i])
    );
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = soc_p ? ACK : IDLE;
      ACK:     nxt = soc_p ? ACK : REQ;
      REQ:     nxt = ~|eoc_v ? WAIT : REQ;
      WAIT:    nxt = &eoc_v ? UPD : WAIT;
      UPD:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Handshake outputs are registered from the next state so they track the state register exactly
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      eoc_p    <= 1'b1;
      soc_v    <= 1'b0;
      mode_r   <= MODE_HOLD;
      v_r      <= '0;
      pos      <= '0;
      ovf      <= '0;
      step_cnt <= '0;
    end else begin
      state <= nxt;
      eoc_p <= nxt == IDLE;
      soc_v <= nxt == REQ;
      if (state == IDLE && soc_p) mode_r <= mode;
      if (state == WAIT && &eoc_v) v_r <= v;
      if (state == UPD) begin
        pos      <= new_pos;
        ovf      <= new_ovf;
        step_cnt <= step_cnt + CW'(1);
      end
    end
  end
endmodule
